seletor_proximo_andar: RTL and testbench
========================================

Name: seletor_proximo_andar

Overview:
- Destination selector for the elevator controller. It latches floor call buttons into a pending-request vector and picks the next target floor from the current floor and travel direction.
- It drives the 4-bit destination register directly downstream: proximo_andar feeds D and carrega_destino feeds enable.
- After loading a target, it waits for the arrival pulse, clears the served request, then selects again.

Parameters:
N_ANDARES, 8, number of floors served (2..16); floors are numbered 0..N_ANDARES-1.

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous reset, active-low
botoes  input  N_ANDARES  call buttons, level, one bit per floor, synchronous to clock
andar_atual  input  4  current floor of the car
chegou  input  1  one-cycle pulse: car has reached proximo_andar
proximo_andar  output  4  selected target floor (to destination register D)
carrega_destino  output  1  one-cycle load strobe (to destination register enable)
direcao  output  1  1 = up, 0 = down
pendentes  output  N_ANDARES  pending requests
ocupado  output  1  high when state is not OCIOSO
db_estado  output  2  FSM state for debug

Behaviour:
- Interface: one clock; reset `clear` is asynchronous and active-low.
- Reset (clear=0, asynchronous):
  - pendentes=0, internal previous-button sample=0.
  - proximo_andar=0, direcao=1, carrega_destino=0, state OCIOSO.
  - Reset mid-operation discards all pending requests and any loaded target.
  - A button held through reset registers as a new press at the first edge after clear rises.
- Request capture:
  - At each edge, bit i is set if botoes[i]=1 and its previous sample was 0 (rising edge only).
  - Holding a button produces one request.
  - Pressing an already-pending floor has no effect.
- Request clear:
  - In ESPERA with chegou=1, pendentes[proximo_andar] is cleared at that edge.
  - If a new press for the same floor occurs on the same edge, the clear wins.
- FSM states (db_estado encoding):
  - OCIOSO=00: if pendentes!=0, go to BUSCA; else stay.
  - BUSCA=01: register the target and direcao, go to CARREGA. Target selection, from registered pendentes:
    - If pendentes[andar_atual]=1, target=andar_atual; direcao unchanged.
    - Else if direcao=1: nearest pending floor strictly above andar_atual. If none, direcao becomes 0 and the target is the nearest pending floor below.
    - Else (direcao=0): the mirror rule — nearest below first; if none, direcao becomes 1 and the target is the nearest above.
    - If pendentes=0 (only possible right after reset), go to OCIOSO with outputs unchanged.
  - CARREGA=10: carrega_destino=1 for exactly this cycle (Moore output), go to ESPERA.
  - ESPERA=11: hold; on chegou=1, clear the served bit and go to OCIOSO.
- chegou is ignored in OCIOSO, BUSCA and CARREGA.
- proximo_andar and direcao change only on the BUSCA→CARREGA edge and are stable otherwise.
- Latency:
  - Button rising edge sampled at edge k, from OCIOSO: pendentes bit set after k.
  - BUSCA after k+1.
  - proximo_andar valid and carrega_destino=1 after k+2, for one cycle.
- Re-selection after arrival: chegou at edge m gives OCIOSO after m, BUSCA after m+1, next carrega_destino after m+2 (if requests remain).
- andar_atual >= N_ANDARES: treated as above all floors, so no "above" candidates exist.
- Requests arriving during ESPERA are accumulated; they do not preempt the loaded target.

Test Plan:
- Reset then idle: clear=0 mid-ESPERA with pendentes=8'b0010_0100 → immediately pendentes=0, state 00, proximo_andar=0, direcao=1, carrega_destino=0.
- Single call: andar_atual=0, pulse botoes[5] at edge k → pendentes=8'b0010_0000 after k; proximo_andar=5 and carrega_destino=1 only after k+2. Then chegou → pendentes=0, state 00.
- Direction priority: andar_atual=3, direcao=1, pendentes floors {1,6,7} → target 6, direcao=1. After chegou with andar_atual=6 → target 7. After next chegou with andar_atual=7 → target 1, direcao=0.
- Held button and duplicate: hold botoes[2] high 10 cycles → exactly one request, one carrega_destino pulse. A second press of floor 2 while pending → no change.
- Same-floor call and chegou collision: in ESPERA on floor 4, botoes[4] rises on the same edge as chegou → pendentes[4]=0, state 00. Spurious chegou in OCIOSO → no state change.
- Request at current floor: andar_atual=2, pendentes={2,5}, direcao=0 → target 2 selected first; direcao stays 0.

Source files
------------

// File: rtl/seletor_proximo_andar_if.sv
// Bus between the elevator destination selector and its surroundings:
// call buttons and car position in, selected target and status out.
interface seletor_proximo_andar_if #(
    parameter int N_ANDARES = 8
);
    logic [N_ANDARES-1:0] botoes;
    logic [3:0]           andar_atual;
    logic                 chegou;
    logic [3:0]           proximo_andar;
    logic                 carrega_destino;
    logic                 direcao;
    logic [N_ANDARES-1:0] pendentes;
    logic                 ocupado;
    logic [1:0]           db_estado;

    // Side that presses buttons and reports car position
    modport master (
        output botoes, andar_atual, chegou,
        input  proximo_andar, carrega_destino, direcao, pendentes, ocupado, db_estado
    );

    // The selector itself
    modport slave (
        input  botoes, andar_atual, chegou,
        output proximo_andar, carrega_destino, direcao, pendentes, ocupado, db_estado
    );
endinterface

// File: rtl/seletor_proximo_andar.sv
// Destination selector for the elevator controller.
// Latches floor calls into a pending vector, picks the next target from the
// current floor and travel direction, strobes it into the downstream
// destination register, then waits for arrival before selecting again.
module seletor_proximo_andar #(
    parameter int N_ANDARES = 8
) (
    input  logic                   clock,
    input  logic                   clear,
    seletor_proximo_andar_if.slave bus
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        BUSCA   = 2'b01,
        CARREGA = 2'b10,
        ESPERA  = 2'b11
    } estado_t;

    estado_t              estado_q, estado_d;
    logic [N_ANDARES-1:0] pendentes_q, pendentes_d;
    logic [N_ANDARES-1:0] botoes_ant_q, botoes_ant_d;
    logic [3:0]           proximo_q, proximo_d;
    logic                 direcao_q, direcao_d;

    logic [15:0]          pend_ext;
    logic [15:0]          pend_work;
    logic                 acima_ok, abaixo_ok, atual_ok;
    logic [3:0]           acima_idx, abaixo_idx;

    // Nearest pending floor above and below the car; floors past N_ANDARES read as empty
    always_comb begin
        pend_ext   = 16'(pendentes_q);
        acima_ok   = 1'b0;
        acima_idx  = 4'd0;
        abaixo_ok  = 1'b0;
        abaixo_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend_ext[i] && (4'(i) > bus.andar_atual)) begin
                acima_ok  = 1'b1;
                acima_idx = 4'(i);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (pend_ext[i] && (4'(i) < bus.andar_atual)) begin
                abaixo_ok  = 1'b1;
                abaixo_idx = 4'(i);
            end
        end
        atual_ok = pend_ext[bus.andar_atual];
    end

    // Request capture/clear and next-state logic; a served-floor clear overrides a same-edge press
    always_comb begin
        estado_d     = estado_q;
        proximo_d    = proximo_q;
        direcao_d    = direcao_q;
        botoes_ant_d = bus.botoes;
        pend_work    = 16'(pendentes_q | (bus.botoes & ~botoes_ant_q));

        case (estado_q)
            OCIOSO: begin
                if (pendentes_q != '0) begin
                    estado_d = BUSCA;
                end
            end
            BUSCA: begin
                if (pendentes_q == '0) begin
                    estado_d = OCIOSO;
                end else begin
                    estado_d = CARREGA;
                    if (atual_ok) begin
                        proximo_d = bus.andar_atual;
                    end else if (direcao_q) begin
                        if (acima_ok) begin
                            proximo_d = acima_idx;
                        end else begin
                            direcao_d = 1'b0;
                            proximo_d = abaixo_idx;
                        end
                    end else begin
                        if (abaixo_ok) begin
                            proximo_d = abaixo_idx;
                        end else begin
                            direcao_d = 1'b1;
                            proximo_d = acima_idx;
                        end
                    end
                end
            end
            CARREGA: begin
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (bus.chegou) begin
                    pend_work[proximo_q] = 1'b0;
                    estado_d             = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        pendentes_d = pend_work[N_ANDARES-1:0];
    end

    // State and datapath registers; reset drops all requests and any loaded target
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            estado_q     <= OCIOSO;
            pendentes_q  <= '0;
            botoes_ant_q <= '0;
            proximo_q    <= 4'd0;
            direcao_q    <= 1'b1;
        end else begin
            estado_q     <= estado_d;
            pendentes_q  <= pendentes_d;
            botoes_ant_q <= botoes_ant_d;
            proximo_q    <= proximo_d;
            direcao_q    <= direcao_d;
        end
    end

    assign bus.proximo_andar   = proximo_q;
    assign bus.direcao         = direcao_q;
    assign bus.pendentes       = pendentes_q;
    assign bus.carrega_destino = (estado_q == CARREGA);
    assign bus.ocupado         = (estado_q != OCIOSO);
    assign bus.db_estado       = estado_q;

endmodule

// File: tb/tb_seletor_proximo_andar.sv
// Self-checking bench for seletor_proximo_andar: each load strobe is checked
// against a queue of expected (target, direction) pairs pushed with the calls.
module tb_seletor_proximo_andar;

    localparam int N = 8;

    typedef struct packed {
        logic [3:0] andar;
        logic       dir;
    } exp_t;

    logic clock = 1'b0;
    logic clear;
    int   assertions = 0;
    int   failures   = 0;
    exp_t exp_q[$];

    seletor_proximo_andar_if #(.N_ANDARES(N)) bus ();

    seletor_proximo_andar #(.N_ANDARES(N)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] a, input logic d);
        exp_q.push_back({a, d});
    endtask

    // Step until a load strobe is visible, bounded
    task automatic wait_load(output bit found);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (bus.carrega_destino === 1'b1) found = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        clear           = 1'b1;
        bus.botoes      = '0;
        bus.andar_atual = 4'd0;
        bus.chegou      = 1'b0;
        #1 clear = 1'b0;
        #2;
        assertions++;
        if ({bus.pendentes, bus.db_estado, bus.proximo_andar, bus.direcao, bus.carrega_destino, bus.ocupado} !== {8'h00, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state: pend=%h st=%0d prox=%0d dir=%b load=%b ocup=%b, expected 00/0/0/1/0/0",
                     bus.pendentes, bus.db_estado, bus.proximo_andar, bus.direcao, bus.carrega_destino, bus.ocupado);
        end
        step();
        step();
        clear = 1'b1;
    endtask

    task automatic test_single_call();
        exp_t e;
        bus.andar_atual = 4'd0;
        bus.botoes      = 8'h20;
        push_exp(4'd5, 1'b1);
        step();
        bus.botoes = '0;
        assertions++;
        if (bus.pendentes !== 8'h20 || bus.carrega_destino !== 1'b0 || bus.db_estado !== 2'd0) begin
            failures++;
            $display("[TB] FAIL single_k: pend=%h load=%b st=%0d, expected 20/0/0", bus.pendentes, bus.carrega_destino, bus.db_estado);
        end
        step();
        assertions++;
        if (bus.db_estado !== 2'd1 || bus.carrega_destino !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_k1: st=%0d load=%b, expected 1/0", bus.db_estado, bus.carrega_destino);
        end
        step();
        e = exp_q.pop_front();
        assertions++;
        if (bus.carrega_destino !== 1'b1 || bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
            failures++;
            $display("[TB] FAIL single_k2: load=%b prox=%0d dir=%b, expected 1/%0d/%b", bus.carrega_destino, bus.proximo_andar, bus.direcao, e.andar, e.dir);
        end
        step();
        assertions++;
        if (bus.db_estado !== 2'd3 || bus.carrega_destino !== 1'b0 || bus.ocupado !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_wait: st=%0d load=%b ocup=%b, expected 3/0/1", bus.db_estado, bus.carrega_destino, bus.ocupado);
        end
        bus.chegou = 1'b1;
        step();
        bus.chegou = 1'b0;
        assertions++;
        if (bus.pendentes !== 8'h00 || bus.db_estado !== 2'd0) begin
            failures++;
            $display("[TB] FAIL single_arrive: pend=%h st=%0d, expected 00/0", bus.pendentes, bus.db_estado);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   found;
        bus.andar_atual = 4'd0;
        bus.botoes      = 8'h24;
        push_exp(4'd2, 1'b1);
        step();
        bus.botoes = '0;
        wait_load(found);
        e = exp_q.pop_front();
        assertions++;
        if (!found || bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
            failures++;
            $display("[TB] FAIL rmid_load: found=%b prox=%0d dir=%b, expected %0d/%b", found, bus.proximo_andar, bus.direcao, e.andar, e.dir);
        end
        step();
        bus.botoes = 8'h08;
        #2 clear = 1'b0;
        #1;
        assertions++;
        if ({bus.pendentes, bus.db_estado, bus.proximo_andar, bus.direcao, bus.carrega_destino} !== {8'h00, 2'd0, 4'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rmid_async: pend=%h st=%0d prox=%0d dir=%b load=%b, expected 00/0/0/1/0",
                     bus.pendentes, bus.db_estado, bus.proximo_andar, bus.direcao, bus.carrega_destino);
        end
        step();
        clear = 1'b1;
        step();
        push_exp(4'd3, 1'b1);
        assertions++;
        if (bus.pendentes !== 8'h08) begin
            failures++;
            $display("[TB] FAIL rmid_held_press: pend=%h, expected 08", bus.pendentes);
        end
        wait_load(found);
        e = exp_q.pop_front();
        assertions++;
        if (!found || bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
            failures++;
            $display("[TB] FAIL rmid_reload: found=%b prox=%0d dir=%b, expected %0d/%b", found, bus.proximo_andar, bus.direcao, e.andar, e.dir);
        end
        step();
        bus.andar_atual = 4'd3;
        bus.chegou      = 1'b1;
        step();
        bus.chegou = 1'b0;
        bus.botoes = '0;
        assertions++;
        if (bus.pendentes !== 8'h00 || bus.db_estado !== 2'd0) begin
            failures++;
            $display("[TB] FAIL rmid_arrive: pend=%h st=%0d, expected 00/0", bus.pendentes, bus.db_estado);
        end
    endtask

    task automatic test_direction();
        exp_t e;
        bit   found;
        logic [3:0] arrive[3] = '{4'd6, 4'd7, 4'd1};
        logic [7:0] left[3]   = '{8'h82, 8'h02, 8'h00};
        bus.andar_atual = 4'd3;
        bus.botoes      = 8'hC2;
        push_exp(4'd6, 1'b1);
        push_exp(4'd7, 1'b1);
        push_exp(4'd1, 1'b0);
        step();
        bus.botoes = '0;
        for (int k = 0; k < 3; k++) begin
            wait_load(found);
            e = exp_q.pop_front();
            assertions++;
            if (!found || bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
                failures++;
                $display("[TB] FAIL dir_load%0d: found=%b prox=%0d dir=%b, expected %0d/%b", k, found, bus.proximo_andar, bus.direcao, e.andar, e.dir);
            end
            step();
            bus.andar_atual = arrive[k];
            bus.chegou      = 1'b1;
            step();
            bus.chegou = 1'b0;
            assertions++;
            if (bus.pendentes !== left[k]) begin
                failures++;
                $display("[TB] FAIL dir_left%0d: pend=%h, expected %h", k, bus.pendentes, left[k]);
            end
        end
    endtask

    task automatic test_held_button();
        exp_t e;
        int   pulses = 0;
        bus.andar_atual = 4'd0;
        bus.botoes      = 8'h04;
        push_exp(4'd2, 1'b1);
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.carrega_destino === 1'b1) begin
                pulses++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    assertions++;
                    if (bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
                        failures++;
                        $display("[TB] FAIL held_load: prox=%0d dir=%b, expected %0d/%b", bus.proximo_andar, bus.direcao, e.andar, e.dir);
                    end
                end
            end
        end
        assertions++;
        if (pulses != 1 || bus.pendentes !== 8'h04 || bus.db_estado !== 2'd3) begin
            failures++;
            $display("[TB] FAIL held_once: pulses=%0d pend=%h st=%0d, expected 1/04/3", pulses, bus.pendentes, bus.db_estado);
        end
        bus.botoes = '0;
        step();
        bus.botoes = 8'h04;
        step();
        bus.botoes = '0;
        assertions++;
        if (bus.pendentes !== 8'h04 || bus.db_estado !== 2'd3 || bus.carrega_destino !== 1'b0) begin
            failures++;
            $display("[TB] FAIL held_dup: pend=%h st=%0d load=%b, expected 04/3/0", bus.pendentes, bus.db_estado, bus.carrega_destino);
        end
        bus.andar_atual = 4'd2;
        bus.chegou      = 1'b1;
        step();
        bus.chegou = 1'b0;
        assertions++;
        if (bus.pendentes !== 8'h00) begin
            failures++;
            $display("[TB] FAIL held_arrive: pend=%h, expected 00", bus.pendentes);
        end
    endtask

    task automatic test_collision();
        exp_t e;
        bit   found;
        bus.andar_atual = 4'd4;
        bus.botoes      = 8'h10;
        push_exp(4'd4, 1'b1);
        step();
        bus.botoes = '0;
        wait_load(found);
        e = exp_q.pop_front();
        assertions++;
        if (!found || bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
            failures++;
            $display("[TB] FAIL coll_load: found=%b prox=%0d dir=%b, expected %0d/%b", found, bus.proximo_andar, bus.direcao, e.andar, e.dir);
        end
        step();
        bus.botoes = 8'h10;
        bus.chegou = 1'b1;
        step();
        bus.chegou = 1'b0;
        assertions++;
        if (bus.pendentes !== 8'h00 || bus.db_estado !== 2'd0) begin
            failures++;
            $display("[TB] FAIL coll_clear_wins: pend=%h st=%0d, expected 00/0", bus.pendentes, bus.db_estado);
        end
        step();
        step();
        bus.chegou = 1'b1;
        step();
        bus.chegou = 1'b0;
        assertions++;
        if (bus.pendentes !== 8'h00 || bus.db_estado !== 2'd0 || bus.carrega_destino !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coll_spurious: pend=%h st=%0d load=%b, expected 00/0/0", bus.pendentes, bus.db_estado, bus.carrega_destino);
        end
        bus.botoes = '0;
    endtask

    task automatic test_current_floor();
        exp_t e;
        bit   found;
        bus.andar_atual = 4'd5;
        bus.botoes      = 8'h04;
        push_exp(4'd2, 1'b0);
        step();
        bus.botoes = '0;
        wait_load(found);
        e = exp_q.pop_front();
        assertions++;
        if (!found || bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
            failures++;
            $display("[TB] FAIL cur_turn: found=%b prox=%0d dir=%b, expected %0d/%b", found, bus.proximo_andar, bus.direcao, e.andar, e.dir);
        end
        step();
        bus.andar_atual = 4'd2;
        bus.chegou      = 1'b1;
        step();
        bus.chegou = 1'b0;
        bus.botoes = 8'h24;
        push_exp(4'd2, 1'b0);
        step();
        bus.botoes = '0;
        wait_load(found);
        e = exp_q.pop_front();
        assertions++;
        if (!found || bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
            failures++;
            $display("[TB] FAIL cur_here: found=%b prox=%0d dir=%b, expected %0d/%b", found, bus.proximo_andar, bus.direcao, e.andar, e.dir);
        end
        step();
        bus.chegou = 1'b1;
        push_exp(4'd5, 1'b1);
        step();
        bus.chegou = 1'b0;
        assertions++;
        if (bus.db_estado !== 2'd0 || bus.pendentes !== 8'h20) begin
            failures++;
            $display("[TB] FAIL resel_m: st=%0d pend=%h, expected 0/20", bus.db_estado, bus.pendentes);
        end
        step();
        assertions++;
        if (bus.db_estado !== 2'd1) begin
            failures++;
            $display("[TB] FAIL resel_m1: st=%0d, expected 1", bus.db_estado);
        end
        step();
        e = exp_q.pop_front();
        assertions++;
        if (bus.carrega_destino !== 1'b1 || bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
            failures++;
            $display("[TB] FAIL resel_m2: load=%b prox=%0d dir=%b, expected 1/%0d/%b", bus.carrega_destino, bus.proximo_andar, bus.direcao, e.andar, e.dir);
        end
        step();
        bus.andar_atual = 4'd5;
        bus.chegou      = 1'b1;
        step();
        bus.chegou = 1'b0;
    endtask

    task automatic test_out_of_range();
        exp_t e;
        bit   found;
        bus.andar_atual = 4'd12;
        bus.botoes      = 8'h48;
        push_exp(4'd6, 1'b0);
        push_exp(4'd3, 1'b0);
        step();
        bus.botoes = '0;
        wait_load(found);
        e = exp_q.pop_front();
        assertions++;
        if (!found || bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
            failures++;
            $display("[TB] FAIL oor_first: found=%b prox=%0d dir=%b, expected %0d/%b", found, bus.proximo_andar, bus.direcao, e.andar, e.dir);
        end
        step();
        bus.andar_atual = 4'd6;
        bus.chegou      = 1'b1;
        step();
        bus.chegou = 1'b0;
        wait_load(found);
        e = exp_q.pop_front();
        assertions++;
        if (!found || bus.proximo_andar !== e.andar || bus.direcao !== e.dir) begin
            failures++;
            $display("[TB] FAIL oor_second: found=%b prox=%0d dir=%b, expected %0d/%b", found, bus.proximo_andar, bus.direcao, e.andar, e.dir);
        end
        step();
        bus.andar_atual = 4'd3;
        bus.chegou      = 1'b1;
        step();
        bus.chegou = 1'b0;
        assertions++;
        if (bus.pendentes !== 8'h00 || bus.db_estado !== 2'd0 || exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL final_idle: pend=%h st=%0d queued=%0d, expected 00/0/0", bus.pendentes, bus.db_estado, exp_q.size());
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_single_call();
        test_reset_mid();
        test_direction();
        test_held_button();
        test_collision();
        test_current_floor();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
